sm_pipe_reg: RTL and testbench

- Elastic pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
- Sits between two schoolMIPS datapath stages (e.g. fetch -> decode), replacing a bare write-enable register where backpressure is needed.
- Gives full throughput (one transfer per cycle).
- in_ready depends only on internal state, never combinationally on out_ready, so no ready path runs through the stage.

---
 rtl/sm_pipe_reg.sv | 108 ++++++++++
 tb/tb_sm_pipe_reg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sm_pipe_reg.sv
// sm_pipe_reg: elastic pipeline stage with valid/ready handshake and a
// one-entry skid buffer. Sustains one transfer per cycle. in_ready and
// out_valid are decoded from registered state only, so no combinational
// path runs from out_ready or in_valid to any output.
//
// Optional feature: define SM_PIPE_REG_STALL_CNT_EN to build a saturating
// counter of downstream-stall cycles. Without it stall_cnt is tied to 0.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   flush      discard all held data (main/skid contents kept, state -> EMPTY)
//   in_valid   upstream presents in_data
//   in_ready   stage can accept (state != FULL)
//   in_data    upstream payload [WIDTH]
//   out_valid  out_data valid (state != EMPTY)
//   out_ready  downstream accepts
//   out_data   payload from main register [WIDTH]
//   stall_cnt  saturating count of out_valid && !out_ready edges [CNT_WIDTH]
module sm_pipe_reg #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;

  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign out_data  = main_q;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    unique case (state)
      EMPTY: if (in_valid) begin
        main_nxt  = in_data;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (in_valid && out_ready) begin
          main_nxt = in_data;              // back-to-back streaming
        end else if (in_valid) begin
          skid_nxt  = in_data;             // downstream stalled: park in skid
          state_nxt = FULL;
        end else if (out_ready) begin
          state_nxt = EMPTY;               // main keeps its stale value
        end
      end
      FULL: if (out_ready) begin
        main_nxt  = skid_q;                // skid drains behind main, order kept
        state_nxt = BUSY;
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush kills the stage but leaves the data registers untouched; any
    // same-cycle input is dropped.
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
    end
  end

`ifdef SM_PIPE_REG_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  // Saturates at all-ones; only reset clears it, flush does not.
  always_ff @(posedge clk) begin
    if (!rst)
      cnt_q <= '0;
    else if (out_valid && !out_ready && (cnt_q != {CNT_WIDTH{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_sm_pipe_reg.sv
// Self-checking bench for sm_pipe_reg. Reference model is an ordered
// queue of at most two words plus the last value shown on out_data.
module tb_sm_pipe_reg;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] stall_cnt;

  sm_pipe_reg #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [W-1:0] mq[$];
  logic [W-1:0] m_hold = '0;
  int           m_cnt  = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model advance for one clock edge, using the inputs present at the edge.
  task automatic model_edge();
    bit pop, push;
    if (!rst) begin
      mq.delete();
      m_hold = '0;
      m_cnt  = 0;
    end else begin
`ifdef SM_PIPE_REG_STALL_CNT_EN
      if (mq.size() > 0 && !out_ready && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
      pop  = (mq.size() > 0) && out_ready;
      push = in_valid && (mq.size() < 2);
      if (mq.size() > 0) m_hold = mq[0];
      if (flush) mq.delete();
      else begin
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(in_data);
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", W'(out_valid), W'(mq.size() > 0));
    chk("in_ready",  W'(in_ready),  W'(mq.size() < 2));
    chk("out_data",  out_data,      (mq.size() > 0) ? mq[0] : m_hold);
    chk("stall_cnt", W'(stall_cnt), W'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    // reset held two cycles with a handshake offered
    rst = 0; in_valid = 1; in_data = 32'hDEADBEEF;
    step(); step();
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_in_ready", W'(in_ready), 32'h1);
    rst = 1; in_valid = 0;
    step(); step();

    // streaming
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_data = W'(i);
      step();
      chk("stream_data", out_data, W'(i));
    end
    in_valid = 0;
    step(); step();

    // backpressure into skid, then drain in order
    out_ready = 0;
    in_valid = 1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    in_valid = 0;
    chk("skid_in_ready", W'(in_ready), 32'h0);
    chk("skid_hold_a", out_data, 32'hA);
    step(); step(); step();
    out_ready = 1;
    step(); chk("drain_b", out_data, 32'hB);
    step(); chk("drain_empty", W'(out_valid), 32'h0);
    step();

    // flush while FULL with a simultaneous input
    out_ready = 0;
    in_valid = 1; in_data = 32'hA; step();
    in_data = 32'hB; step();
    flush = 1; in_data = 32'hC; step();
    flush = 0; in_valid = 0;
    chk("flush_valid", W'(out_valid), 32'h0);
    chk("flush_ready", W'(in_ready), 32'h1);
    out_ready = 1;
    step(); step(); step();

    // reset mid-operation while FULL
    out_ready = 0;
    in_valid = 1; in_data = 32'h11; step();
    in_data = 32'h22; step();
    in_valid = 0;
    rst = 0; step();
    rst = 1;
    chk("midrst_cnt", W'(stall_cnt), 32'h0);
    out_ready = 1;
    step(); step(); step();

    // long stall: counter saturation (or stays 0 when not built)
    out_ready = 0;
    in_valid = 1; in_data = 32'h5A5A; step();
    in_valid = 0;
    for (int i = 0; i < 20; i++) step();
`ifdef SM_PIPE_REG_STALL_CNT_EN
    chk("stall_sat", W'(stall_cnt), 32'hF);
`else
    chk("stall_off", W'(stall_cnt), 32'h0);
`endif

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 49) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
